// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// forwarding-select encodings and the forwarding decision helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int WAIT_W = 16;

  // MEM wins over WB because it holds the younger result; r0 is hardwired zero.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_reg_write,
    input logic [4:0] wb_rd,
    input logic       wb_reg_write
  );
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return FWD_MEM;
    end
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational EX-operand forwarding select for both ALU operands.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_select(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_select(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline: load-use stalls,
// ID branch flushes, data-memory wait freeze with timeout, and perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if2id_en,
  output logic             id2ex_en,
  output logic             ex2mem_en,
  output logic             if2id_flush,
  output logic             id2ex_bubble,
  output logic             mem2wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;

  logic freeze;
  logic load_use;

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  pipe_fwd_unit u_fwd (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  // Mealy control: priority HALT > freeze > load_use > branch.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    pc_en         = 1'b1;
    if2id_en      = 1'b1;
    id2ex_en      = 1'b1;
    ex2mem_en     = 1'b1;
    if2id_flush   = 1'b0;
    id2ex_bubble  = 1'b0;
    mem2wb_bubble = 1'b0;

    if (state_q == HALT) begin
      pc_en     = 1'b0;
      if2id_en  = 1'b0;
      id2ex_en  = 1'b0;
      ex2mem_en = 1'b0;
    end else if (freeze) begin
      pc_en         = 1'b0;
      if2id_en      = 1'b0;
      id2ex_en      = 1'b0;
      ex2mem_en     = 1'b0;
      mem2wb_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if2id_en     = 1'b0;
      id2ex_bubble = 1'b1;
    end else if (id_branch_taken) begin
      if2id_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;

    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (freeze) begin
          if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Stall cycles exclude HALT; both counters stick at all-ones.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q != HALT) && !pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (if2id_flush && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the pre-edge values.
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign halted       = (state_q == HALT);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/forwarding controller for the 5-stage pipelined CPU. Sits beside the IF2ID, ID2EX, EX2MEM and MEM2WB pipeline registers and drives their enable, bubble and flush controls. Handles load-use stalls, taken-branch flushes in ID, and multi-cycle data-memory waits with a timeout. Also keeps stall and flush performance counters.

## Interface
- MAX_WAIT, 16: maximum consecutive memory-wait cycles before the pipeline halts (1..65535).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads that source.
- id_branch_taken  in  1  the branch resolved in ID is taken.
- ex_rs, ex_rt, ex_rd  in  5 each  register fields of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- mem_rd, wb_rd  in  5 each  destination registers in MEM and WB.
- mem_reg_write, wb_reg_write  in  1 each  write-back valid in MEM and WB.
- mem_req  in  1  the MEM stage is accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if2id_en, id2ex_en, ex2mem_en  out  1 each  load enables for the PC and the pipeline registers.
- if2id_flush  out  1  load a NOP into IF2ID.
- id2ex_bubble  out  1  load a NOP (all control bits 0) into ID2EX.
- mem2wb_bubble  out  1  load a NOP into MEM2WB.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 = register file, 10 = MEM result, 01 = WB result.
- halted  out  1  the controller is in the HALT state.
- mem_err  out  1  sticky flag: the memory-wait timeout fired.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en = 0, HALT cycles excluded.
- flush_count  out  CNT_W  saturating count of cycles with if2id_flush = 1.

## Operation
- The state machine has three states: RUN, MEM_WAIT, HALT. Control outputs are Mealy: they depend on the current state and the current inputs.
- Definitions used below:
  - freeze = mem_req & ~mem_ready.
  - load_use = ex_mem_read & ex_rd != 0 & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- Priority, highest first: HALT > freeze > load_use > id_branch_taken.
- HALT:
  - All enables 0, all flush/bubble outputs 0, halted = 1.
  - HALT is left only by reset.
- Freeze (RUN or MEM_WAIT):
  - All four enables 0 and mem2wb_bubble = 1; no other flush or bubble.
  - id_branch_taken is ignored; it is still presented after the freeze ends.
- Load-use:
  - pc_en = 0 and if2id_en = 0.
  - id2ex_en = 1 and id2ex_bubble = 1.
  - ex2mem_en = 1.
  - A branch asserted in the same cycle is suppressed.
- Branch taken:
  - All enables 1 and if2id_flush = 1.
- Otherwise: all enables 1, no flush or bubble.
- State transitions:
  - RUN → MEM_WAIT when freeze; wait_cnt is loaded with 1.
  - MEM_WAIT & mem_ready → RUN.
  - MEM_WAIT & freeze: if wait_cnt == MAX_WAIT, go to HALT and set mem_err; otherwise increment wait_cnt.
- Forwarding for fwd_a (operand ex_rs):
  - 10 if mem_reg_write & mem_rd != 0 & mem_rd == ex_rs.
  - else 01 if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs.
  - else 00.
  - fwd_b is the same with ex_rt.
  - MEM has priority over WB. Register 0 is never forwarded.
- Counters saturate at all-ones and never wrap.

## Timing
- On reset: state = RUN, wait_cnt = 0, mem_err = 0, halted = 0, both counters = 0.
- Control outputs then show RUN behaviour from the current inputs: with quiet inputs, enables = 1 and flush/bubble = 0.
- Control and forwarding outputs respond to inputs in the same cycle (zero latency).
- Counter, mem_err and halted updates appear on the next clk edge.
- A load-use stall lasts exactly one cycle: after the bubble, the load has moved to MEM and load_use clears.
- Memory wait: n cycles with mem_ready low followed by mem_ready high freezes exactly n cycles.
  - Timeout with MAX_WAIT = m: m consecutive frozen cycles complete normally; halted rises after the (m+1)-th.
- Reset asserted in MEM_WAIT or HALT returns to RUN at the next edge and clears counters and mem_err.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT);
  - constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- Sub-module pipe_fwd_unit: purely combinational, computes fwd_a and fwd_b, instantiated once.
- The state machine, wait_cnt and the counters stay in the top module.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs = 5, id_uses_rs = 1 for one cycle → pc_en = 0, if2id_en = 0, id2ex_bubble = 1; stall_cycles reads 1 afterwards.
- Branch: id_branch_taken = 1 alone → if2id_flush = 1 with all enables 1. Same cycle as a load-use → if2id_flush = 0, and the load-use stall takes effect.
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles, then high → all enables 0 for exactly 3 cycles, mem2wb_bubble = 1 for those cycles, return to RUN, stall_cycles = 3.
- Timeout: MAX_WAIT = 4, mem_ready held low → halted = 1 and mem_err = 1 after the 5th frozen cycle; all enables stay 0. Reset → RUN, mem_err = 0.
- Forwarding: mem_rd = wb_rd = ex_rs = 7, both write-backs valid → fwd_a = 10. Set ex_rs = 0 with mem_rd = 0 → fwd_a = 00. Only wb_rd = ex_rt = 3 with wb_reg_write = 1 → fwd_b = 01.
- Saturation: CNT_W = 4, hold load-use for 20 cycles → stall_cycles stops at 15.
